lz77_decoder: RTL
=================

// Module: lz77_decoder
// PURPOSE
//  Downstream companion of the LZ77 encoder. Accepts one (offset, match_len, char_nxt) code tuple per handshake.
//  Rebuilds the original character stream into a 9-entry search buffer and emits one character per cycle.
//  Asserts finish when the end marker 8'h24 ('$') arrives as char_nxt.
//  Sits between the encoder output bus and the result checker / output memory.
// PARAMETERS
//  SEARCH_DEPTH  9      search buffer entries; valid offsets 0..SEARCH_DEPTH-1
//  OFF_W         4      offset width
//  LEN_W         3      match_len width (max copy length 7)
//  CHAR_W        8      character width
//  END_CHAR      8'h24  end-of-stream marker; never emitted as data
// PORTS
//  clk        in   1       sole clock, rising edge
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       code tuple present
//  in_ready   out  1       decoder can accept a tuple this cycle
//  offset     in   OFF_W   copy distance; 0 = most recently emitted char
//  match_len  in   LEN_W   number of chars to copy before the literal
//  char_nxt   in   CHAR_W  literal following the copy, or END_CHAR
//  out_valid  out  1       out_char valid this cycle (no backpressure)
//  out_char   out  CHAR_W  decoded character
//  finish     out  1       sticky; end of stream reached
//  encode     out  1       constant 0 (decoder-mode flag for the testbench)
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE; in_ready=1; out_valid=0; out_char=0; finish=0.
//    All search buffer entries cleared to 0. A tuple in flight is discarded, including reset asserted mid-COPY.
//  FSM:
//    IDLE: in_ready=1. On in_valid, latch offset, match_len and char_nxt.
//          match_len!=0 -> COPY; else -> LIT.
//    COPY: in_ready=0. Each cycle: c = sbuf[off_r]; shift sbuf (sbuf[0]<=c, sbuf[i]<=sbuf[i-1]).
//          Register out_char<=c, out_valid<=1; len_r<=len_r-1. When len_r==1 -> LIT.
//    LIT:  in_ready=0.
//          char_r==END_CHAR -> DONE; finish<=1; out_valid<=0; buffer unchanged.
//          Otherwise out_char<=char_r; out_valid<=1; shift char_r into sbuf -> IDLE.
//    DONE: in_ready=0; out_valid=0; finish held until reset; in_valid ignored.
//  Outputs are registered. The char produced in a COPY/LIT cycle is visible the following cycle.
//    First char appears 2 cycles after the accepting edge.
//    Per tuple: 1 IDLE + match_len COPY + 1 LIT cycle.
//  out_valid is deasserted in any cycle not preceded by a COPY/LIT emission.
//  offset is held constant during COPY. Because the buffer shifts each cycle, overlapping copies
//    (offset < match_len) replicate correctly.
//  offset >= SEARCH_DEPTH reads 8'h00. Unwritten entries read their reset value 0 (mirrors the encoder).
//  in_valid while in_ready=0 is ignored. The producer holds the tuple until accepted.
//  match_len width fixes the max copy at 7. No wrap-around of len_r (decrements only from >=1).
// STRUCTURE
//  Shared package lz77_pkg holds:
//    OFF_W, LEN_W, CHAR_W, SEARCH_DEPTH, END_CHAR;
//    state encoding IDLE/COPY/LIT/DONE (3'd0..3'd3);
//    shared by lz77_decoder and the encoder.
//  One sub-module: lz77_search_buf
//    SEARCH_DEPTH x CHAR_W shift register;
//    ports shift_en, din, rd_idx, rd_data, clear (sync);
//    out-of-range rd_idx returns 0.
//  Top holds the FSM, latched tuple registers and output registers.
// TESTING
//  1 reset -> in_ready=1, out_valid=0, finish=0, out_char=0. Reset asserted mid-COPY -> same values next cycle.
//  2 tuple (0,0,8'h41) -> single out_char 8'h41, 2 cycles after accept; in_ready high again the following cycle.
//  3 emit 'A','B' as literals, then tuple (1,3,8'h43) -> out_char sequence 41,42,41,43 on consecutive cycles.
//  4 emit 'A', then tuple (0,7,8'h24) -> seven 8'h41 outputs. Then finish=1, no '$' output, in_ready stays 0.
//  5 fresh reset, tuple (12,2,8'h5A) -> outputs 00,00,5A (out-of-range and unwritten entries read 0).
//  6 in_valid pulsed during COPY -> tuple not accepted; output stream unchanged.

Source files
------------

// File: rtl/lz77_pkg.sv
// lz77_pkg: sizes, end marker and FSM state encoding shared by the LZ77 encoder and decoder
package lz77_pkg;
    localparam int SEARCH_DEPTH = 9;
    localparam int OFF_W = 4;
    localparam int LEN_W = 3;
    localparam int CHAR_W = 8;
    localparam logic [CHAR_W-1:0] END_CHAR = 8'h24;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        COPY = 3'd1,
        LIT  = 3'd2,
        DONE = 3'd3
    } state_t;
endpackage

// File: rtl/lz77_decoder_if.sv
// lz77_decoder_if: code tuple handshake in, decoded character stream and status out
interface lz77_decoder_if;
    import lz77_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [OFF_W-1:0]  offset;
    logic [LEN_W-1:0]  match_len;
    logic [CHAR_W-1:0] char_nxt;
    logic              out_valid;
    logic [CHAR_W-1:0] out_char;
    logic              finish;
    logic              encode;
    modport master (output in_valid, offset, match_len, char_nxt,
                    input in_ready, out_valid, out_char, finish, encode);
    modport slave (input in_valid, offset, match_len, char_nxt,
                   output in_ready, out_valid, out_char, finish, encode);
endinterface

// File: rtl/lz77_search_buf.sv
// lz77_search_buf: history shift register; entry 0 holds the most recently emitted character
module lz77_search_buf
    import lz77_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [CHAR_W-1:0] din,
    input  logic [OFF_W-1:0]  rd_idx,
    output logic [CHAR_W-1:0] rd_data
);
    logic [CHAR_W-1:0] mem [SEARCH_DEPTH];
    always_ff @(posedge clk) begin
        if (clear) begin
            mem <= '{default: '0};
        end else if (shift_en) begin
            mem[0] <= din;
            for (int i = 1; i < SEARCH_DEPTH; i++) mem[i] <= mem[i-1];
        end
    end
    // offsets beyond the history read as 0, matching the encoder's view
    assign rd_data = rd_idx < OFF_W'(SEARCH_DEPTH) ? mem[rd_idx] : '0;
endmodule

// File: rtl/lz77_decoder.sv
// lz77_decoder: expands (offset, match_len, char_nxt) tuples into one character per cycle
module lz77_decoder
    import lz77_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    lz77_decoder_if.slave bus
);
    state_t            state;
    logic [OFF_W-1:0]  off_r;
    logic [LEN_W-1:0]  len_r;
    logic [CHAR_W-1:0] char_r;
    logic [CHAR_W-1:0] rd_data;
    logic [CHAR_W-1:0] din;
    logic              shift_en;
    always_comb begin
        shift_en = state == COPY || (state == LIT && char_r != END_CHAR);
        din = state == COPY ? rd_data : char_r;
    end
    lz77_search_buf u_sbuf (
        .clk      (clk),
        .clear    (reset),
        .shift_en (shift_en),
        .din      (din),
        .rd_idx   (off_r),
        .rd_data  (rd_data)
    );
    assign bus.in_ready = state == IDLE;
    assign bus.encode = 1'b0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            off_r <= '0;
            len_r <= '0;
            char_r <= '0;
            bus.out_valid <= 1'b0;
            bus.out_char <= '0;
            bus.finish <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                IDLE: if (bus.in_valid) begin
                    off_r <= bus.offset;
                    len_r <= bus.match_len;
                    char_r <= bus.char_nxt;
                    state <= bus.match_len != '0 ? COPY : LIT;
                end
                // offset stays fixed while the buffer shifts, so overlapping copies replicate
                COPY: begin
                    bus.out_char <= rd_data;
                    bus.out_valid <= 1'b1;
                    len_r <= len_r - 1'b1;
                    if (len_r == LEN_W'(1)) state <= LIT;
                end
                LIT: if (char_r == END_CHAR) begin
                    state <= DONE;
                    bus.finish <= 1'b1;
                end else begin
                    bus.out_char <= char_r;
                    bus.out_valid <= 1'b1;
                    state <= IDLE;
                end
                default: state <= DONE;
            endcase
        end
    end
endmodule
